// File: rtl/fifo_tx_sequencer.sv
// Drains a first-word-fall-through byte FIFO under frame control and serializes
// each byte MSB-first onto tx_bit, holding every bit for BIT_DIV clock cycles.
module fifo_tx_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 5,
    parameter int BIT_DIV    = 4,
    parameter int STALL_MAX  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read,
    output logic                  tx_bit,
    output logic                  tx_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);

    localparam int DIV_W   = (BIT_DIV > 1)    ? $clog2(BIT_DIV)    : 1;
    localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int STALL_W = (STALL_MAX > 1)  ? $clog2(STALL_MAX)  : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic [DIV_W-1:0]      div_cnt, div_cnt_nxt;
    logic [STALL_W-1:0]    stall_cnt, stall_cnt_nxt;
    logic [LEN_WIDTH-1:0]  remaining, remaining_nxt;
    logic                  underrun_nxt;
    logic                  load;
    logic                  div_last, bit_last, stall_last;

    assign div_last   = (div_cnt == DIV_W'(BIT_DIV - 1));
    assign bit_last   = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign stall_last = (stall_cnt == STALL_W'(STALL_MAX - 1));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        div_cnt_nxt   = div_cnt;
        stall_cnt_nxt = '0;
        remaining_nxt = remaining;
        underrun_nxt  = 1'b0;
        load          = 1'b0;
        fifo_read     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (frame_len == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt     = S_FETCH;
                        remaining_nxt = frame_len;
                    end
                end
            end
            S_FETCH: begin
                if (!fifo_empty) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end else if (stall_last) begin
                    underrun_nxt = 1'b1;
                    state_nxt    = S_IDLE;
                end else begin
                    stall_cnt_nxt = stall_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                div_cnt_nxt = div_cnt + 1'b1;
                if (div_last) begin
                    div_cnt_nxt = '0;
                    shreg_nxt   = shreg << 1;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_last) begin
                        // NOTE: blocking assignment here, so the decremented count is visible on the next line.
                        remaining_nxt = remaining - 1'b1;
                        if (remaining_nxt == '0) begin
                            state_nxt = S_DONE;
                        end else if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = S_FETCH;
                        end
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Disabling wins over everything: no pop, no pulse, straight back to idle.
        if (!en) begin
            state_nxt    = S_IDLE;
            load         = 1'b0;
            underrun_nxt = 1'b0;
        end

        if (load) begin
            fifo_read   = 1'b1;
            shreg_nxt   = fifo_data;
            bit_cnt_nxt = '0;
            div_cnt_nxt = '0;
        end

        if (state_nxt != S_SHIFT && !load) begin
            shreg_nxt   = '0;
            bit_cnt_nxt = '0;
            div_cnt_nxt = '0;
        end

        if (state_nxt == S_IDLE || state_nxt == S_DONE) begin
            remaining_nxt = '0;
            stall_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            stall_cnt <= '0;
            remaining <= '0;
            tx_bit    <= 1'b0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            div_cnt   <= div_cnt_nxt;
            stall_cnt <= stall_cnt_nxt;
            remaining <= remaining_nxt;
            tx_bit    <= (state_nxt == S_SHIFT) && shreg_nxt[DATA_WIDTH-1];
            tx_valid  <= (state_nxt == S_SHIFT);
            busy      <= (state_nxt == S_FETCH) || (state_nxt == S_SHIFT);
            done      <= (state_nxt == S_DONE);
            underrun  <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_tx_sequencer.sv
// Directed bench for fifo_tx_sequencer: a bench-side FIFO feeds the DUT and a
// timeline model of each frame is compared against the outputs every cycle.
module tb_fifo_tx_sequencer;

    localparam int DW   = 8;
    localparam int LW   = 5;
    localparam int BD   = 4;
    localparam int SM   = 16;
    localparam int MAXL = 128;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic          start;
    logic [LW-1:0] frame_len;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_read;
    logic          tx_bit;
    logic          tx_valid;
    logic          busy;
    logic          done;
    logic          underrun;

    fifo_tx_sequencer #(
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW),
        .BIT_DIV   (BD),
        .STALL_MAX (SM)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .start     (start),
        .frame_len (frame_len),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_read (fifo_read),
        .tx_bit    (tx_bit),
        .tx_valid  (tx_valid),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    int    t     = -1;
    int    exp_len = 0;
    bit    chk_on = 1'b0;
    string tname  = "";
    logic  rd_seen = 1'b0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] wq_d[$];
    int            wq_t[$];
    logic [DW-1:0] m_bytes[$];
    int            m_av[$];

    logic exp_v[MAXL], exp_bit[MAXL], exp_busy[MAXL], exp_d[MAXL], exp_u[MAXL], exp_rd[MAXL];
    int   cnt_v, cnt_rd, cnt_d, cnt_u;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {26'd0, busy, tx_valid, tx_bit, done, underrun, fifo_read};
    endfunction

    function automatic logic [31:0] exp_outs(input int c);
        return {26'd0, exp_busy[c], exp_v[c], exp_bit[c], exp_d[c], exp_u[c], exp_rd[c]};
    endfunction

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? '0 : fq[0];
    endtask

    task automatic flush();
        fq.delete();
        wq_d.delete();
        wq_t.delete();
        m_bytes.delete();
        m_av.delete();
        drive_fifo();
    endtask

    // Byte enters the FIFO so that it is visible from cycle av of the frame (0 = preloaded).
    task automatic add_byte(input logic [DW-1:0] b, input int av);
        m_bytes.push_back(b);
        m_av.push_back(av);
        if (av == 0) fq.push_back(b);
        else begin
            wq_d.push_back(b);
            wq_t.push_back(av);
        end
    endtask

    always @(negedge clk) rd_seen = fifo_read;

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
        if (rd_seen && fq.size() > 0) fq.delete(0);
        while (wq_t.size() > 0 && wq_t[0] == t) begin
            fq.push_back(wq_d[0]);
            wq_d.delete(0);
            wq_t.delete(0);
        end
        drive_fifo();
    endtask

    // Frame timeline: cycle 0 is the cycle after the edge that accepted start.
    task automatic build(input int flen, input int abort_t);
        int  s, p, e;
        bit  stalled;
        for (int c = 0; c < MAXL; c++) begin
            exp_v[c] = 0; exp_bit[c] = 0; exp_busy[c] = 0;
            exp_d[c] = 0; exp_u[c] = 0;   exp_rd[c] = 0;
        end
        stalled = 0;
        e = -1;
        p = 0;
        if (flen == 0) begin
            exp_d[0] = 1;
            exp_len  = 4;
        end else begin
            for (int j = 0; j < flen; j++) begin
                if (j > 0 && j < m_bytes.size() && m_av[j] <= e) begin
                    p = e;
                end else begin
                    s = e + 1;
                    if (j < m_bytes.size() && m_av[j] <= s + SM - 1) begin
                        p = (m_av[j] > s) ? m_av[j] : s;
                        for (int c = s; c <= p; c++) exp_busy[c] = 1;
                    end else begin
                        for (int c = s; c < s + SM; c++) exp_busy[c] = 1;
                        exp_u[s + SM] = 1;
                        exp_len = s + SM + 3;
                        stalled = 1;
                        break;
                    end
                end
                exp_rd[p] = 1;
                for (int c = p + 1; c <= p + DW * BD; c++) begin
                    exp_v[c]    = 1;
                    exp_busy[c] = 1;
                    exp_bit[c]  = m_bytes[j][DW - 1 - (c - p - 1) / BD];
                end
                e = p + DW * BD;
            end
            if (!stalled) begin
                exp_d[e + 1] = 1;
                exp_len = e + 4;
            end
        end
        if (abort_t >= 0) begin
            exp_rd[abort_t] = 0;
            for (int c = abort_t + 1; c < MAXL; c++) begin
                exp_v[c] = 0; exp_bit[c] = 0; exp_busy[c] = 0;
                exp_d[c] = 0; exp_u[c] = 0;   exp_rd[c] = 0;
            end
            exp_len = abort_t + 5;
        end
    endtask

    always @(negedge clk) begin
        if (chk_on && t >= 0 && t < exp_len) begin
            check($sformatf("%s.c%0d", tname, t), outs(), exp_outs(t));
            cnt_v  += int'(tx_valid);
            cnt_rd += int'(fifo_read);
            cnt_d  += int'(done);
            cnt_u  += int'(underrun);
        end
    end

    task automatic run_test(input string name, input int flen, input int abort_t,
                            input int inj_t, input int max_t);
        tname = name;
        cnt_v = 0; cnt_rd = 0; cnt_d = 0; cnt_u = 0;
        drive_fifo();
        en        = 1'b1;
        start     = 1'b1;
        frame_len = LW'(flen);
        t         = -1;
        chk_on    = 1'b1;
        while (t < exp_len && t < max_t) begin
            tick();
            if (t == 0) start = 1'b0;
            if (t == inj_t) begin
                start     = 1'b1;
                frame_len = LW'(5);
            end
            if (t == inj_t + 1) start = 1'b0;
            if (t == abort_t) en = 1'b0;
            if (t == abort_t + 3) en = 1'b1;
        end
        chk_on = 1'b0;
    endtask

    task automatic totals(input int v, input int rd, input int d, input int u);
        check({tname, ".valid_cycles"}, cnt_v, v);
        check({tname, ".pops"}, cnt_rd, rd);
        check({tname, ".done_pulses"}, cnt_d, d);
        check({tname, ".underruns"}, cnt_u, u);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int sum;
        reset_n = 1'b0; en = 1'b0; start = 1'b0; frame_len = '0;
        fifo_empty = 1'b1; fifo_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", outs(), 32'd0);
        reset_n = 1'b1;
        en = 1'b1;
        idle(2);
        check("post_reset_idle", outs(), 32'd0);

        // T1: two preloaded bytes, gap-free
        flush();
        add_byte(8'hA5, 0);
        add_byte(8'h3C, 0);
        build(2, -1);
        sum = 0;
        for (int c = 0; c < MAXL; c++) sum += int'(exp_v[c]);
        check("pin.t1_valid", sum, 64);
        check("pin.t1_done65", 32'(exp_d[65]), 32'd1);
        check("pin.t1_bit1", 32'(exp_bit[1]), 32'd1);
        check("pin.t1_bit5", 32'(exp_bit[5]), 32'd0);
        check("pin.t1_bit33", 32'(exp_bit[33]), 32'd0);
        check("pin.t1_bit41", 32'(exp_bit[41]), 32'd1);
        run_test("T1", 2, -1, -1, MAXL);
        totals(64, 2, 1, 0);
        idle(3);

        // T2: second byte arrives 5 cycles after the first ends
        flush();
        add_byte(8'hC3, 0);
        add_byte(8'h5A, 37);
        build(2, -1);
        check("pin.t2_pop37", 32'(exp_rd[37]), 32'd1);
        check("pin.t2_gap", 32'({exp_v[33], exp_v[37], exp_v[38]}), 32'b001);
        run_test("T2", 2, -1, -1, MAXL);
        totals(64, 2, 1, 0);
        idle(3);

        // T3: one byte for a three-byte frame -> underrun
        flush();
        add_byte(8'h96, 0);
        build(3, -1);
        check("pin.t3_under49", 32'(exp_u[49]), 32'd1);
        check("pin.t3_busy48", 32'({exp_busy[48], exp_busy[49]}), 32'b10);
        run_test("T3", 3, -1, -1, MAXL);
        totals(32, 1, 0, 1);
        idle(3);

        // T4: zero-length frame, FIFO not empty yet untouched
        flush();
        add_byte(8'h55, 0);
        build(0, -1);
        run_test("T4", 0, -1, -1, MAXL);
        totals(0, 0, 1, 0);
        check("T4.fifo_kept", fq.size(), 1);
        idle(3);

        // T5: enable dropped in the middle of byte 1
        flush();
        add_byte(8'hF0, 0);
        add_byte(8'h0F, 0);
        build(2, 10);
        run_test("T5", 2, 10, -1, MAXL);
        totals(10, 1, 0, 0);
        idle(3);

        // T5b: start mid-frame with a different length is ignored
        flush();
        add_byte(8'h81, 0);
        add_byte(8'h7E, 0);
        build(2, -1);
        run_test("T5b", 2, -1, 10, MAXL);
        totals(64, 2, 1, 0);
        idle(3);

        // T6: asynchronous reset mid-shift
        flush();
        add_byte(8'hFF, 0);
        add_byte(8'hFF, 0);
        build(2, -1);
        run_test("T6", 2, -1, -1, 20);
        #2;
        reset_n = 1'b0;
        #1;
        check("T6.async_reset", outs(), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        flush();
        idle(2);
        check("T6.idle_after", outs(), 32'd0);

        // T7: single byte after reset recovery
        flush();
        add_byte(8'h6D, 0);
        build(1, -1);
        run_test("T7", 1, -1, -1, MAXL);
        totals(32, 1, 1, 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
